// File: rtl/l2_ring_filler.sv
`default_nettype none
// ============================================================================
// l2_ring_filler: ring line-fill requester. It takes one L2 miss at a time and
// writes the LINE_SIZE returned beats into the L2 data array.
// Revision: 1.0
// ============================================================================
module l2_ring_filler #(
  parameter int LINE_SIZE  = 8,
  parameter int LINE_BYTES = 64,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_valid,
  input  logic [63:0] miss_addr,
  output logic        miss_ready,
  output logic        ring_req,
  output logic [63:0] ring_addr,
  input  logic        ring_ready,
  input  logic [63:0] ring_rdata,
  output logic        l2_wr_en,
  output logic [63:0] l2_wr_addr,
  output logic [63:0] l2_wr_data,
  output logic        fill_done,
  output logic        fill_err,
  output logic [63:0] fill_addr,
  output logic        busy
);

  localparam int                BEAT_W    = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;
  localparam int                TO_W      = $clog2(TIMEOUT);
  localparam logic [63:0]       LINE_MASK = 64'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_SIZE - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              miss_ready_q, miss_ready_d;
  logic              ring_req_q, ring_req_d;
  logic [63:0]       ring_addr_q, ring_addr_d;
  logic              l2_wr_en_q, l2_wr_en_d;
  logic [63:0]       l2_wr_addr_q, l2_wr_addr_d;
  logic [63:0]       l2_wr_data_q, l2_wr_data_d;
  logic              fill_done_q, fill_done_d;
  logic              fill_err_q, fill_err_d;
  logic [63:0]       fill_addr_q, fill_addr_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    tcnt_d       = tcnt_q;
    ring_addr_d  = ring_addr_q;
    l2_wr_en_d   = 1'b0;
    l2_wr_addr_d = l2_wr_addr_q;
    l2_wr_data_d = l2_wr_data_q;
    fill_addr_d  = fill_addr_q;

    case (state_q)
      S_IDLE: begin
        if (miss_valid) begin
          // ring_addr doubles as the latched line base for the whole fill
          ring_addr_d = miss_addr & ~LINE_MASK;
          beat_d      = '0;
          tcnt_d      = '0;
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        if (ring_ready) begin
          l2_wr_en_d   = 1'b1;
          l2_wr_addr_d = ring_addr_q + (64'(beat_q) << 3);
          l2_wr_data_d = ring_rdata;
          tcnt_d       = '0;
          if (beat_q == LAST_BEAT) begin
            beat_d      = '0;
            fill_addr_d = ring_addr_q;
            state_d     = S_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end else if (tcnt_q == TO_LIMIT) begin
          tcnt_d      = '0;
          beat_d      = '0;
          fill_addr_d = ring_addr_q;
          state_d     = S_ERR;
        end else begin
          tcnt_d = tcnt_q + TO_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered decodes of the upcoming state
    miss_ready_d = (state_d == S_IDLE);
    ring_req_d   = (state_d == S_REQ);
    fill_done_d  = (state_d == S_DONE);
    fill_err_d   = (state_d == S_ERR);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      beat_q       <= '0;
      tcnt_q       <= '0;
      miss_ready_q <= 1'b1;
      ring_req_q   <= 1'b0;
      ring_addr_q  <= '0;
      l2_wr_en_q   <= 1'b0;
      l2_wr_addr_q <= '0;
      l2_wr_data_q <= '0;
      fill_done_q  <= 1'b0;
      fill_err_q   <= 1'b0;
      fill_addr_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      tcnt_q       <= tcnt_d;
      miss_ready_q <= miss_ready_d;
      ring_req_q   <= ring_req_d;
      ring_addr_q  <= ring_addr_d;
      l2_wr_en_q   <= l2_wr_en_d;
      l2_wr_addr_q <= l2_wr_addr_d;
      l2_wr_data_q <= l2_wr_data_d;
      fill_done_q  <= fill_done_d;
      fill_err_q   <= fill_err_d;
      fill_addr_q  <= fill_addr_d;
      busy_q       <= busy_d;
    end
  end

  assign miss_ready = miss_ready_q;
  assign ring_req   = ring_req_q;
  assign ring_addr  = ring_addr_q;
  assign l2_wr_en   = l2_wr_en_q;
  assign l2_wr_addr = l2_wr_addr_q;
  assign l2_wr_data = l2_wr_data_q;
  assign fill_done  = fill_done_q;
  assign fill_err   = fill_err_q;
  assign fill_addr  = fill_addr_q;
  assign busy       = busy_q;

endmodule
`default_nettype wire
